// File: rtl/serial_addsub_unit_if.sv
// Operand/result handshake bundle for serial_addsub_unit; the master drives operands and
// out_ready, and the slave (the arithmetic unit) returns in_ready and the registered result.
interface serial_addsub_unit_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic             mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, mode, a, b, cin, out_ready,
        input  in_ready, out_valid, result, cout, ovf
    );

    modport slave (
        input  in_valid, mode, a, b, cin, out_ready,
        output in_ready, out_valid, result, cout, ovf
    );
endinterface

// File: rtl/serial_addsub_unit.sv
// Digit-serial add/subtract (A+B+cin / A-B-bin) with carry/borrow and signed overflow; ADDSUB_SAT_EN adds saturation.
// Latency: out_valid rises NDIG edges after the accept edge; initiation interval NDIG+2.
// Backpressure: result/cout/ovf held in DONE until out_ready; in_ready is low from accept until DONE is left.
module serial_addsub_unit #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serial_addsub_unit_if.slave  bus
);
    localparam int NDIG  = WIDTH / DIGIT;
    localparam int MSB   = WIDTH - 1;
    localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NDIG - 1);

    generate
        if (WIDTH < 2) begin : g_bad_width
            $error("serial_addsub_unit: WIDTH must be at least 2");
        end
        if (DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_digit
            $error("serial_addsub_unit: DIGIT must be positive and divide WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q,     state_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic             carry_q,     carry_d;
    logic             mode_q,      mode_d;
    logic [WIDTH-1:0] a_q,         a_d;
    logic [WIDTH-1:0] b_q,         b_d;
    logic [WIDTH-1:0] result_q,    result_d;
    logic             cout_q,      cout_d;
    logic             ovf_q,       ovf_d;
    logic             in_ready_q,  in_ready_d;
    logic             out_valid_q, out_valid_d;

    logic [DIGIT-1:0] dig_a;
    logic [DIGIT-1:0] dig_b;
    logic [DIGIT:0]   dig_sum;
    logic [WIDTH-1:0] res_wr;
    logic [WIDTH-1:0] res_fin;
    logic             ovf_raw;

    // One digit slice of the ripple; b_q already holds ~b when subtracting.
    always_comb begin
        dig_a   = a_q[cnt_q*DIGIT +: DIGIT];
        dig_b   = b_q[cnt_q*DIGIT +: DIGIT];
        dig_sum = {1'b0, dig_a} + {1'b0, dig_b} + {{DIGIT{1'b0}}, carry_q};

        res_wr = result_q;
        res_wr[cnt_q*DIGIT +: DIGIT] = dig_sum[DIGIT-1:0];

        ovf_raw = (a_q[MSB] == b_q[MSB]) && (res_wr[MSB] != a_q[MSB]);

        res_fin = res_wr;
`ifdef ADDSUB_SAT_EN
        if (ovf_raw) begin
            res_fin = a_q[MSB] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        carry_d     = carry_q;
        mode_d      = mode_q;
        a_d         = a_q;
        b_d         = b_q;
        result_d    = result_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;

        case (state_q)
            S_IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    a_d        = bus.a;
                    b_d        = bus.mode ? ~bus.b : bus.b;
                    carry_d    = bus.mode ? ~bus.cin : bus.cin;
                    mode_d     = bus.mode;
                    cnt_d      = '0;
                    in_ready_d = 1'b0;
                    state_d    = S_RUN;
                end
            end

            S_RUN: begin
                result_d = res_wr;
                carry_d  = dig_sum[DIGIT];
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    result_d    = res_fin;
                    // Subtraction ran as A + ~B + ~bin, so the borrow is the inverted carry.
                    cout_d      = mode_q ? ~dig_sum[DIGIT] : dig_sum[DIGIT];
                    ovf_d       = ovf_raw;
                    cnt_d       = '0;
                    out_valid_d = 1'b1;
                    state_d     = S_DONE;
                end
            end

            S_DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = S_IDLE;
                end
            end

            default: begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                state_d     = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            mode_q      <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            result_q    <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            carry_q     <= carry_d;
            mode_q      <= mode_d;
            a_q         <= a_d;
            b_q         <= b_d;
            result_q    <= result_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;

    a_hold_result: assert property (@(posedge clk) disable iff (!rst_n)
        (out_valid_q && !bus.out_ready) |=> (out_valid_q && $stable(result_q) && $stable(cout_q) && $stable(ovf_q)));

    a_ready_excl: assert property (@(posedge clk) disable iff (!rst_n)
        !(in_ready_q && out_valid_q));
endmodule

// File: tb/tb_serial_addsub_unit.sv
// Bench for serial_addsub_unit: DIGIT=1 and DIGIT=4 instances at WIDTH=8, scoreboard queues
// filled by the drivers and drained by negedge monitors, checked against an integer arithmetic model.
module tb_serial_addsub_unit;
    localparam int W = 8;

    typedef struct {
        logic [W-1:0] res;
        logic         co;
        logic         ov;
        int           due;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    serial_addsub_unit_if #(.WIDTH(W)) if8 ();
    serial_addsub_unit_if #(.WIDTH(W)) if4 ();

    serial_addsub_unit #(.WIDTH(W), .DIGIT(1)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8));
    serial_addsub_unit #(.WIDTH(W), .DIGIT(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    exp_t q0[$];
    exp_t q1[$];

    bit rdy_rand  = 1'b0;
    bit rdy_force = 1'b1;

    logic         pv   [2];
    logic         pf   [2];
    logic [W-1:0] pres [2];
    logic         pco  [2];
    logic         pov  [2];

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #2;
        if8.out_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_force;
        if4.out_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_force;
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [W-1:0] r, input logic c, input logic o);
        exp_t e;
        e.res = r;
        e.co  = c;
        e.ov  = o;
        e.due = 0;
        return e;
    endfunction

    // Plain integer arithmetic: unsigned value for result/carry/borrow, signed value for overflow.
    function automatic exp_t model(input bit m, input logic [W-1:0] a, input logic [W-1:0] b, input bit c);
        exp_t r;
        int ua, ub, sa, sb, u, s;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (!m) begin
            u    = ua + ub + int'(c);
            s    = sa + sb + int'(c);
            r.co = (u > 255);
        end else begin
            u    = ua - ub - int'(c);
            s    = sa - sb - int'(c);
            r.co = (u < 0);
        end
        r.res = u[W-1:0];
        r.ov  = (s > 127) || (s < -128);
`ifdef ADDSUB_SAT_EN
        if (r.ov) r.res = (s > 127) ? 8'h7F : 8'h80;
`endif
        r.due = 0;
        return r;
    endfunction

    task automatic mon(input int i, input logic vld, input logic rdy, input logic inr,
                       input logic [W-1:0] res, input logic co, input logic ov);
        exp_t  e;
        string tag;
        bit    empty;
        tag = (i == 0) ? "d1" : "d4";
        if (!rst_n) begin
            pv[i] = 1'b0;
            pf[i] = 1'b0;
            return;
        end
        if (vld) begin
            chk({tag, "_in_ready_in_done"}, inr, 1'b0);
            if (!pv[i] || pf[i]) begin
                empty = (i == 0) ? (q0.size() == 0) : (q1.size() == 0);
                if (empty) begin
                    chk({tag, "_unexpected_out_valid"}, vld, 1'b0);
                end else begin
                    e = (i == 0) ? q0.pop_front() : q1.pop_front();
                    chk({tag, "_result"}, res, e.res);
                    chk({tag, "_cout"}, co, e.co);
                    chk({tag, "_ovf"}, ov, e.ov);
                    chk({tag, "_latency_cycle"}, cyc, e.due);
                end
            end else begin
                chk({tag, "_hold_result"}, res, pres[i]);
                chk({tag, "_hold_cout"}, co, pco[i]);
                chk({tag, "_hold_ovf"}, ov, pov[i]);
            end
        end else if (pv[i] && !pf[i]) begin
            chk({tag, "_out_valid_dropped_without_ready"}, vld, 1'b1);
        end
        pv[i]   = vld;
        pf[i]   = vld && rdy;
        pres[i] = res;
        pco[i]  = co;
        pov[i]  = ov;
    endtask

    always @(negedge clk) mon(0, if8.out_valid, if8.out_ready, if8.in_ready, if8.result, if8.cout, if8.ovf);
    always @(negedge clk) mon(1, if4.out_valid, if4.out_ready, if4.in_ready, if4.result, if4.cout, if4.ovf);

    task automatic drive(input int i, input bit m, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit c, input exp_t e);
        int n;
        bit ok;
        n  = 0;
        ok = 1'b0;
        @(posedge clk);
        #2;
        if (i == 0) begin
            if8.mode = m; if8.a = a; if8.b = b; if8.cin = c; if8.in_valid = 1'b1;
        end else begin
            if4.mode = m; if4.a = a; if4.b = b; if4.cin = c; if4.in_valid = 1'b1;
        end
        while (!ok && n < 300) begin
            @(negedge clk);
            n++;
            if ((i == 0) ? if8.in_ready : if4.in_ready) ok = 1'b1;
        end
        if (!ok) begin
            chk("accept_timeout", ok, 1'b1);
        end else begin
            e.due = cyc + 1 + ((i == 0) ? 8 : 2);
            if (i == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
        @(posedge clk);
        #2;
        // Operands are scrambled after accept; the unit must be working from its latched copy.
        if (i == 0) begin
            if8.in_valid = 1'b0; if8.a = W'($urandom); if8.b = W'($urandom); if8.cin = $urandom_range(0, 1) != 0;
            if8.mode = $urandom_range(0, 1) != 0;
        end else begin
            if4.in_valid = 1'b0; if4.a = W'($urandom); if4.b = W'($urandom); if4.cin = $urandom_range(0, 1) != 0;
            if4.mode = $urandom_range(0, 1) != 0;
        end
    endtask

    task automatic drain();
        int n;
        bit done;
        n    = 0;
        done = 1'b0;
        while (!done && n < 1000) begin
            @(negedge clk);
            n++;
            done = (q0.size() == 0) && (q1.size() == 0) && !if8.out_valid && !if4.out_valid;
        end
        chk("drain_timeout", done, 1'b1);
    endtask

    initial begin
        bit seen;
        rst_n        = 1'b0;
        if8.in_valid = 1'b0; if8.mode = 1'b0; if8.a = '0; if8.b = '0; if8.cin = 1'b0;
        if4.in_valid = 1'b0; if4.mode = 1'b0; if4.a = '0; if4.b = '0; if4.cin = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_d1_in_ready", if8.in_ready, 1'b1);
        chk("rst_d1_out_valid", if8.out_valid, 1'b0);
        chk("rst_d1_result", if8.result, 8'h00);
        chk("rst_d1_cout", if8.cout, 1'b0);
        chk("rst_d1_ovf", if8.ovf, 1'b0);
        chk("rst_d4_in_ready", if4.in_ready, 1'b1);
        chk("rst_d4_out_valid", if4.out_valid, 1'b0);
        chk("rst_d4_result", if4.result, 8'h00);
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        drive(0, 1'b0, 8'h3C, 8'h25, 1'b0, mk(8'h61, 1'b0, 1'b0));
        drive(0, 1'b1, 8'h10, 8'h20, 1'b0, mk(8'hF0, 1'b1, 1'b0));
        drive(0, 1'b1, 8'h10, 8'h20, 1'b1, mk(8'hEF, 1'b1, 1'b0));
`ifdef ADDSUB_SAT_EN
        drive(0, 1'b0, 8'h7F, 8'h01, 1'b0, mk(8'h7F, 1'b0, 1'b1));
`else
        drive(0, 1'b0, 8'h7F, 8'h01, 1'b0, mk(8'h80, 1'b0, 1'b1));
`endif
        drive(1, 1'b0, 8'hFF, 8'h01, 1'b1, mk(8'h01, 1'b1, 1'b0));
        drain();

        // Hold the result in DONE while a new request waits.
        rdy_force = 1'b0;
        drive(0, 1'b0, 8'h3C, 8'h25, 1'b0, mk(8'h61, 1'b0, 1'b0));
        seen = 1'b0;
        for (int n = 0; n < 50 && !seen; n++) begin
            @(negedge clk);
            seen = if8.out_valid;
        end
        chk("bp_reached_done", seen, 1'b1);
        @(posedge clk);
        #2;
        if8.in_valid = 1'b1; if8.mode = 1'b0; if8.a = 8'h55; if8.b = 8'h11; if8.cin = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_in_ready_held_low", if8.in_ready, 1'b0);
            chk("bp_out_valid_held", if8.out_valid, 1'b1);
        end
        rdy_force = 1'b1;
        drive(0, 1'b0, 8'h55, 8'h11, 1'b0, mk(8'h66, 1'b0, 1'b0));
        drain();

        // Asynchronous reset in the middle of RUN discards the operation.
        drive(0, 1'b0, 8'hA5, 8'h5A, 1'b1, mk(8'h00, 1'b1, 1'b0));
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        q0.delete();
        #1;
        chk("midrun_rst_out_valid", if8.out_valid, 1'b0);
        chk("midrun_rst_result", if8.result, 8'h00);
        chk("midrun_rst_in_ready", if8.in_ready, 1'b1);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        drive(0, 1'b0, 8'h01, 8'h01, 1'b0, mk(8'h02, 1'b0, 1'b0));
        drain();

        rdy_rand = 1'b1;
        fork
            begin
                for (int k = 0; k < 40; k++) begin
                    logic [W-1:0] ra, rb;
                    bit rm, rc;
                    ra = W'($urandom); rb = W'($urandom);
                    rm = $urandom_range(0, 1) != 0; rc = $urandom_range(0, 1) != 0;
                    drive(0, rm, ra, rb, rc, model(rm, ra, rb, rc));
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                end
            end
            begin
                for (int k = 0; k < 40; k++) begin
                    logic [W-1:0] ra, rb;
                    bit rm, rc;
                    ra = W'($urandom); rb = W'($urandom);
                    rm = $urandom_range(0, 1) != 0; rc = $urandom_range(0, 1) != 0;
                    drive(1, rm, ra, rb, rc, model(rm, ra, rb, rc));
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                end
            end
        join
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
